// File: rtl/player_mover_pkg.sv
// Shared definitions for the player motion controller: FSM state encoding,
// one-hot direction constants and a one-hot check helper.
package player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    DEAD = 2'd2
  } playerState_t;

  localparam logic [3:0] DIR_U = 4'b1000;
  localparam logic [3:0] DIR_D = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_L = 4'b0001;

  function automatic logic isOneHot(input logic [3:0] b);
    return (b == DIR_U) || (b == DIR_D) || (b == DIR_R) || (b == DIR_L);
  endfunction

endpackage

// File: rtl/player_mover_btn_repeat.sv
// Button front end: press-edge detection, one-hot validation and the
// tick-paced auto-repeat counter. Emits a single-cycle moveReq with the
// requested direction.
module btn_repeat
  import player_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       btnClk,
  input  logic       rst,
  input  logic       tick,
  input  logic       freeze,
  input  logic       clear,
  input  logic       inHeld,
  input  logic       block,
  input  logic [3:0] btns,
  output logic       press,
  output logic       stillHeld,
  output logic       moveReq,
  output logic [3:0] moveDir
);

  localparam int unsigned CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

  logic [3:0]    prevBtns;
  logic [CW-1:0] holdCnt;
  logic          repeatDue;

  // Classify the current buttons against last cycle and raise move requests.
  always_comb begin
    press     = isOneHot(btns) && (btns != prevBtns);
    stillHeld = isOneHot(btns) && (btns == prevBtns);
    repeatDue = inHeld && stillHeld && tick && (holdCnt == HOLD_LAST);
    moveReq   = !block && (press || repeatDue);
    moveDir   = btns;
  end

  // Edge history and repeat counter; history keeps tracking even while dead.
  always_ff @(posedge btnClk) begin
    if (!rst) begin
      prevBtns <= '0;
      holdCnt  <= '0;
    end else if (clear) begin
      prevBtns <= btns;
      holdCnt  <= '0;
    end else if (!freeze) begin
      prevBtns <= btns;
      if (!block) begin
        if (press) begin
          holdCnt <= '0;
        end else if (inHeld && stillHeld) begin
          if (tick) holdCnt <= repeatDue ? '0 : holdCnt + CW'(1);
        end else begin
          holdCnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/player_mover.sv
// Player motion controller: turns one-hot buttons into screen positions with
// step moves, auto-repeat and boxed-in death detection.
// Build option: PLAYER_WRAP_EN makes edge moves wrap instead of clamp.
module player_mover
  import player_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned STEP       = 12,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned DEAD_TICKS = 3
) (
  input  logic             btnClk,
  input  logic             rst,
  input  logic             tick,
  input  logic             playerDisable,
  input  logic             restart,
  input  logic [3:0]       btns,
  input  logic [3:0]       moveEn,
  input  logic [POS_W-1:0] startX,
  input  logic [POS_W-1:0] startY,
  input  logic [POS_W-1:0] objW,
  input  logic [POS_W-1:0] objH,
  output logic [POS_W-1:0] xPos,
  output logic [POS_W-1:0] yPos,
  output logic             moved,
  output logic             deadPulse,
  output logic             dead,
  output logic [1:0]       state
);

  localparam int unsigned EW = POS_W + 2;
  localparam int unsigned BW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(DEAD_TICKS - 1);
  localparam logic [EW-1:0] STEP_E   = EW'(STEP);
  localparam logic [EW-1:0] SCR_W_E  = EW'(SCREEN_W);
  localparam logic [EW-1:0] SCR_H_E  = EW'(SCREEN_H);

  playerState_t   stateQ, stateNext;
  logic [BW-1:0]  blkCnt, blkNext;
  logic [POS_W-1:0] xNext, yNext;
  logic           movedNext, deadPulseNext;
  logic           press, stillHeld, moveReq;
  logic [3:0]     moveDir;
  logic           deathTick, applyMove;
  logic [EW-1:0]  xE, yE, wE, hE, candX, candY;
  logic [EW-1:0]  edgeU, edgeD, edgeL, edgeR;

  btn_repeat #(.HOLD_TICKS(HOLD_TICKS)) uRepeat (
    .btnClk    (btnClk),
    .rst       (rst),
    .tick      (tick),
    .freeze    (playerDisable),
    .clear     (restart),
    .inHeld    (stateQ == HELD),
    .block     (stateQ == DEAD),
    .btns      (btns),
    .press     (press),
    .stillHeld (stillHeld),
    .moveReq   (moveReq),
    .moveDir   (moveDir)
  );

  // Candidate position for the requested direction, widened to avoid underflow.
  always_comb begin
    xE = {2'b00, xPos};
    yE = {2'b00, yPos};
    wE = {2'b00, objW};
    hE = {2'b00, objH};
`ifdef PLAYER_WRAP_EN
    edgeU = SCR_H_E - hE;
    edgeD = '0;
    edgeL = SCR_W_E - wE;
    edgeR = '0;
`else
    edgeU = '0;
    edgeD = SCR_H_E - hE;
    edgeL = '0;
    edgeR = SCR_W_E - wE;
`endif
    candX = xE;
    candY = yE;
    case (moveDir)
      DIR_U: candY = (yE >= STEP_E) ? yE - STEP_E : edgeU;
      DIR_D: candY = (yE + hE + STEP_E <= SCR_H_E) ? yE + STEP_E : edgeD;
      DIR_L: candX = (xE >= STEP_E) ? xE - STEP_E : edgeL;
      DIR_R: candX = (xE + wE + STEP_E <= SCR_W_E) ? xE + STEP_E : edgeR;
      default: ;
    endcase
  end

  // Next-state, death detection and move application; death wins over a move.
  always_comb begin
    stateNext     = stateQ;
    blkNext       = blkCnt;
    xNext         = xPos;
    yNext         = yPos;
    movedNext     = 1'b0;
    deadPulseNext = 1'b0;
    deathTick     = (stateQ != DEAD) && tick && (moveEn == '0) && (blkCnt == BLK_LAST);
    applyMove     = 1'b0;
    if (stateQ != DEAD) begin
      if (tick) blkNext = (moveEn == '0) ? blkCnt + BW'(1) : '0;
      if (deathTick) begin
        stateNext     = DEAD;
        deadPulseNext = 1'b1;
        blkNext       = '0;
      end else begin
        if (press || (stateQ == HELD && stillHeld)) stateNext = HELD;
        else                                        stateNext = IDLE;
        applyMove = moveReq && ((moveEn & moveDir) != '0);
        if (applyMove) begin
          xNext     = candX[POS_W-1:0];
          yNext     = candY[POS_W-1:0];
          movedNext = (xNext != xPos) || (yNext != yPos);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge btnClk) begin
    if (!rst || restart) stateQ <= IDLE;
    else if (!playerDisable) stateQ <= stateNext;
  end

  // Position, blocked-tick counter and pulse registers; pulses drop while frozen.
  always_ff @(posedge btnClk) begin
    if (!rst || restart) begin
      xPos      <= startX;
      yPos      <= startY;
      blkCnt    <= '0;
      moved     <= 1'b0;
      deadPulse <= 1'b0;
    end else if (playerDisable) begin
      moved     <= 1'b0;
      deadPulse <= 1'b0;
    end else begin
      xPos      <= xNext;
      yPos      <= yNext;
      blkCnt    <= blkNext;
      moved     <= movedNext;
      deadPulse <= deadPulseNext;
    end
  end

  assign dead  = (stateQ == DEAD);
  assign state = stateQ;

endmodule

// File: tb/tb_player_mover.sv
// Self-checking bench for player_mover: directed scenarios followed by random
// stimulus, all compared each cycle against a behavioural reference model.
module tb_player_mover;

  localparam int SW = 640, SH = 480, PW = 10, STEP = 12, HT = 4, DT = 3;
`ifdef PLAYER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          btnClk = 1'b0;
  logic          rst, tick, playerDisable, restart;
  logic [3:0]    btns, moveEn;
  logic [PW-1:0] startX, startY, objW, objH, xPos, yPos;
  logic          moved, deadPulse, dead;
  logic [1:0]    state;

  player_mover #(
    .SCREEN_W(SW), .SCREEN_H(SH), .POS_W(PW), .STEP(STEP),
    .HOLD_TICKS(HT), .DEAD_TICKS(DT)
  ) dut (
    .btnClk(btnClk), .rst(rst), .tick(tick), .playerDisable(playerDisable),
    .restart(restart), .btns(btns), .moveEn(moveEn), .startX(startX),
    .startY(startY), .objW(objW), .objH(objH), .xPos(xPos), .yPos(yPos),
    .moved(moved), .deadPulse(deadPulse), .dead(dead), .state(state)
  );

  always #5 btnClk = ~btnClk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mx, my, mHold, mBlk;
  bit mHeld, mDead, mMoved, mDeadP;
  logic [3:0] mPrev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    bit oh, press, same, want, death;
    int nx, ny, w, h;
    w = int'(objW);
    h = int'(objH);
    if (!rst || restart) begin
      mx = int'(startX); my = int'(startY);
      mHeld = 0; mDead = 0; mHold = 0; mBlk = 0;
      mMoved = 0; mDeadP = 0;
      mPrev = rst ? btns : 4'b0000;
    end else if (playerDisable) begin
      mMoved = 0; mDeadP = 0;
    end else begin
      mMoved = 0; mDeadP = 0;
      oh    = ($countones(btns) == 1);
      press = oh && (btns != mPrev);
      same  = oh && (btns == mPrev);
      if (!mDead) begin
        death = tick && (moveEn == 4'b0000) && (mBlk + 1 >= DT);
        if (tick) mBlk = (moveEn == 4'b0000) ? mBlk + 1 : 0;
        if (death) begin
          mDead = 1; mDeadP = 1; mBlk = 0; mHeld = 0;
        end else begin
          want = 0;
          if (press) begin
            want = 1; mHeld = 1; mHold = 0;
          end else if (mHeld && same) begin
            if (tick) begin
              mHold++;
              if (mHold == HT) begin want = 1; mHold = 0; end
            end
          end else begin
            mHeld = 0; mHold = 0;
          end
          if (want && ((moveEn & btns) != 4'b0000)) begin
            nx = mx; ny = my;
            case (btns)
              4'b1000: ny = (my >= STEP) ? my - STEP : (WRAP ? SH - h : 0);
              4'b0100: ny = (my + h + STEP <= SH) ? my + STEP : (WRAP ? 0 : SH - h);
              4'b0010: nx = (mx + w + STEP <= SW) ? mx + STEP : (WRAP ? 0 : SW - w);
              4'b0001: nx = (mx >= STEP) ? mx - STEP : (WRAP ? SW - w : 0);
              default: ;
            endcase
            mMoved = (nx != mx) || (ny != my);
            mx = nx; my = ny;
          end
        end
      end
      mPrev = btns;
    end
  endtask

  task automatic cyc();
    modelStep();
    @(posedge btnClk);
    #1;
    chk("xPos", 32'(xPos), 32'(mx));
    chk("yPos", 32'(yPos), 32'(my));
    chk("state", 32'(state), mDead ? 32'd2 : (mHeld ? 32'd1 : 32'd0));
    chk("moved", 32'(moved), 32'(mMoved));
    chk("deadPulse", 32'(deadPulse), 32'(mDeadP));
    chk("dead", 32'(dead), 32'(mDead));
  endtask

  initial begin
    int movedCnt;
    int sel;
    rst = 1'b0; tick = 1'b0; playerDisable = 1'b0; restart = 1'b0;
    btns = 4'b0000; moveEn = 4'hF;
    startX = 10'd100; startY = 10'd200; objW = 10'd16; objH = 10'd20;

    // Reset state
    cyc();
    chk("rst_x", 32'(xPos), 32'd100);
    chk("rst_y", 32'(yPos), 32'd200);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dead", 32'(dead), 32'd0);

    // Press R and hold for 8 ticks
    rst = 1'b1; btns = 4'b0010;
    cyc();
    chk("press_x", 32'(xPos), 32'd112);
    movedCnt = moved ? 1 : 0;
    for (int k = 0; k < 16; k++) begin
      tick = (k % 2 == 0);
      cyc();
      if (moved) movedCnt++;
    end
    tick = 1'b0;
    chk("hold_x", 32'(xPos), 32'd136);
    chk("hold_moves", 32'(movedCnt), 32'd3);

    // Reset mid-hold
    rst = 1'b0;
    cyc();
    chk("midrst_x", 32'(xPos), 32'd100);
    chk("midrst_state", 32'(state), 32'd0);
    rst = 1'b1; btns = 4'b0000;
    cyc();

    // Freeze while held
    btns = 4'b0010;
    cyc();
    playerDisable = 1'b1; tick = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("frozen_x", 32'(xPos), 32'd112);
    chk("frozen_state", 32'(state), 32'd1);
    playerDisable = 1'b0; tick = 1'b0; btns = 4'b0000;
    cyc();

    // Screen edges
    startX = 10'd620; startY = 10'd5; restart = 1'b1;
    cyc();
    restart = 1'b0; btns = 4'b0010;
    cyc();
    chk("edge_r", 32'(xPos), WRAP ? 32'd0 : 32'd624);
    chk("edge_r_moved", 32'(moved), 32'd1);
    btns = 4'b0000; cyc();
    btns = 4'b1000; cyc();
    chk("edge_u", 32'(yPos), WRAP ? 32'd460 : 32'd0);
    btns = 4'b0000; cyc();
    btns = 4'b1000; cyc();
    btns = 4'b0000; cyc();

    // Multi-hot and disabled direction
    startX = 10'd100; startY = 10'd200; restart = 1'b1;
    cyc();
    restart = 1'b0; btns = 4'b1010;
    cyc();
    chk("multihot_x", 32'(xPos), 32'd100);
    chk("multihot_state", 32'(state), 32'd0);
    btns = 4'b0000; cyc();
    moveEn = 4'b1101; btns = 4'b0010;
    cyc();
    chk("blocked_x", 32'(xPos), 32'd100);
    chk("blocked_moved", 32'(moved), 32'd0);
    btns = 4'b0000; moveEn = 4'hF; cyc();

    // Boxed in -> DEAD
    moveEn = 4'b0000;
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("death_pulse", 32'(deadPulse), 32'd1);
    chk("death_dead", 32'(dead), 32'd1);
    chk("death_state", 32'(state), 32'd2);
    cyc();
    chk("death_pulse_end", 32'(deadPulse), 32'd0);
    moveEn = 4'hF; btns = 4'b1000;
    cyc();
    chk("dead_nomove_y", 32'(yPos), 32'd200);
    restart = 1'b1;
    cyc();
    chk("restart_dead", 32'(dead), 32'd0);
    chk("restart_x", 32'(xPos), 32'd100);
    restart = 1'b0; btns = 4'b0000;
    cyc();

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 199) != 0);
      restart       = ($urandom_range(0, 99) == 0);
      playerDisable = ($urandom_range(0, 19) == 0);
      tick          = ($urandom_range(0, 2) == 0);
      if (!rst || restart) begin
        objW   = PW'($urandom_range(4, 64));
        objH   = PW'($urandom_range(4, 64));
        startX = PW'($urandom_range(0, SW - int'(objW)));
        startY = PW'($urandom_range(0, SH - int'(objH)));
      end
      if ($urandom_range(0, 5) == 0) begin
        sel = $urandom_range(0, 6);
        case (sel)
          0:       btns = 4'b0000;
          1:       btns = 4'b0001;
          2:       btns = 4'b0010;
          3:       btns = 4'b0100;
          4:       btns = 4'b1000;
          default: btns = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 5)       moveEn = 4'hF;
        else if (sel < 8)  moveEn = 4'($urandom_range(0, 15));
        else               moveEn = 4'h0;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_mover.md
# player_mover

Parametrised player motion controller for the rectangle-sprite game. It converts one-hot button inputs into absolute screen positions, with configurable step and screen size and tick-paced auto-repeat while a button is held. It detects a boxed-in player (no move enable for a run of ticks) and latches a dead state until restart. It sits between the button debouncer and the VGA object renderer, which consumes the position and size outputs.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- POS_W, 10, position/size width in bits
- STEP, 12, pixels per move
- HOLD_TICKS, 4, ticks between repeated moves while held (≥1)
- DEAD_TICKS, 3, consecutive all-blocked ticks before death (≥1)
- btnClk  in  1  sole clock
- rst  in  1  synchronous, active-low reset
- tick  in  1  one-cycle pace strobe (btnClk domain)
- playerDisable  in  1  freeze: no moves, counters and state hold
- restart  in  1  reload start position, leave DEAD
- btns  in  4  {U,D,R,L} = 8,4,2,1 one-hot
- moveEn  in  4  per-direction enable, same bit order
- startX, startY  in  POS_W  start position
- objW, objH  in  POS_W  object size
- xPos, yPos  out  POS_W  registered top-left position
- moved  out  1  one-cycle pulse on each applied move
- deadPulse  out  1  one-cycle pulse on entering DEAD
- dead  out  1  level, high in DEAD
- state  out  2  current FSM state

## Operation
- States: IDLE=0, HELD=1, DEAD=2.
- IDLE: a valid press (btns one-hot, differs from the previous-cycle btns) applies one move that cycle → HELD, holdCnt=0.
- HELD: each tick increments holdCnt; at holdCnt==HOLD_TICKS-1 apply a move and clear it. Release or change of btns → IDLE (a change to a new one-hot value is treated as a fresh press in the same cycle).
- Multi-hot or zero btns: no move, treated as released.
- A move is applied only if moveEn of that direction is 1; otherwise no position change and no moved pulse.
- Move arithmetic (compute in POS_W+2 bits, no underflow):
  - U: y≥STEP ? y-STEP : edge; D: y+objH+STEP≤SCREEN_H ? y+STEP : edge
  - L: x≥STEP ? x-STEP : edge; R: x+objW+STEP≤SCREEN_W ? x+STEP : edge
  - edge value set by Configuration.
- Death: on each tick with moveEn==0, blkCnt increments, otherwise it clears. Reaching DEAD_TICKS → DEAD, deadPulse for one cycle. In DEAD, btns are ignored.
- restart (any state, not in reset): xPos/yPos ← startX/startY, counters cleared → IDLE. restart beats a press in the same cycle.
- playerDisable: all registers hold. It has lower priority than rst and restart.

## Timing
- Reset (rst=0 at edge): xPos=startX, yPos=startY, state=IDLE, moved=0, deadPulse=0, dead=0, holdCnt=blkCnt=0. Reset mid-hold or in DEAD takes effect on the next edge.
- Press-to-position latency: 1 cycle. Registered xPos/yPos and moved are valid on the edge after the press.
- Repeat move: 1 cycle after the HOLD_TICKS-th tick.
- deadPulse and dead rise on the edge after the DEAD_TICKS-th blocked tick.
- The death check is evaluated before moves. If the death tick and a move coincide, no move is applied.

## Configuration
- PLAYER_WRAP_EN defined: edge behaviour wraps to the opposite side.
  - U→SCREEN_H-objH, D→0, L→SCREEN_W-objW, R→0.
- Undefined: edge behaviour clamps.
  - U→0, D→SCREEN_H-objH, L→0, R→SCREEN_W-objW.
- A clamped move whose position changes still pulses moved. A move with no change does not.

## Structure
- player_pkg: state encoding (IDLE/HELD/DEAD), direction bit constants DIR_U/D/R/L=8/4/2/1.
- Sub-module btn_repeat: press-edge detection, one-hot check, holdCnt; emits a single-cycle moveReq plus direction to the FSM/datapath in player_mover.

## Test plan
- Reset with startX=100, startY=200 → xPos=100, yPos=200, state=0, dead=0.
- btns=2, moveEn=4'hF, held 8 ticks (HOLD_TICKS=4) → xPos 112 one cycle after press, then 124 and 136; three moved pulses.
- xPos=620, objW=16, press R → WRAP_EN: 0; clamp: 624. yPos=5, objH=20, press U → WRAP_EN: 460; clamp: 0.
- moveEn=0 for 3 ticks → deadPulse high exactly one cycle, dead=1, state=2; btns=8 → no move. restart → xPos/yPos=start, dead=0.
- btns=4'b1010 → no move, state=0. Press R with moveEn[1]=0 → no move, no moved pulse.
- rst=0 mid-HELD at xPos=136 → next edge xPos=startX, state=0. playerDisable=1 while held → position frozen across ticks.
